// File: rtl/riscv_mem_arbiter.sv
// Arbitrates IF fetches and DM loads/stores onto one single-ported memory.
// One transaction in flight; DM has priority, IF is protected by a starvation counter.
module riscv_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req_valid,
    input  logic [31:0] if_req_addr,
    output logic        if_req_ready,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    input  logic        dm_req_valid,
    input  logic        dm_req_we,
    input  logic [31:0] dm_req_addr,
    input  logic [31:0] dm_req_wdata,
    input  logic [3:0]  dm_req_be,
    output logic        dm_req_ready,
    output logic        dm_rsp_valid,
    output logic [31:0] dm_rsp_data,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_we,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_be,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        busy,
    output logic        err_timeout
);

    localparam logic [31:0] RESET_VALUE         = '0;
    localparam logic [31:0] NOP_INSTRUCTION     = 32'h0000_0013;
    localparam logic [3:0]  MEM_BYTE_ENABLE_ALL = 4'hF;
    localparam logic [3:0]  STARVE_MAX          = 4'(STARVE_LIMIT);
    localparam logic [7:0]  TMO_LAST            = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_grant_dm;
    logic        w_grant_if;
    logic        w_rsp;
    logic        w_timeout;
    logic        r_is_dm;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [3:0]  r_starve;
    logic [7:0]  r_tmo;
    logic        r_if_rsp_valid;
    logic [31:0] r_if_rsp_data;
    logic        r_dm_rsp_valid;
    logic [31:0] r_dm_rsp_data;
    logic        r_err;

    always_comb begin
        w_grant_dm = 1'b0;
        w_grant_if = 1'b0;
        if (r_state == S_IDLE) begin
            if (dm_req_valid && !(if_req_valid && r_starve == STARVE_MAX))
                w_grant_dm = 1'b1;
            else if (if_req_valid)
                w_grant_if = 1'b1;
        end
    end

    // A response arriving on the timeout cycle takes precedence over the abort.
    assign w_rsp     = (r_state == S_WAIT) && mem_rsp_valid;
    assign w_timeout = (r_state == S_WAIT) && !mem_rsp_valid && (r_tmo == TMO_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_dm || w_grant_if) w_next = S_ISSUE;
            S_ISSUE: if (mem_req_ready)            w_next = S_WAIT;
            S_WAIT:  if (w_rsp || w_timeout)       w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_is_dm        <= 1'b0;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_wdata        <= '0;
            r_be           <= '0;
            r_starve       <= '0;
            r_tmo          <= '0;
            r_if_rsp_valid <= 1'b0;
            r_if_rsp_data  <= RESET_VALUE;
            r_dm_rsp_valid <= 1'b0;
            r_dm_rsp_data  <= RESET_VALUE;
            r_err          <= 1'b0;
        end else begin
            r_if_rsp_valid <= 1'b0;
            r_dm_rsp_valid <= 1'b0;

            if (w_grant_dm) begin
                r_is_dm <= 1'b1;
                r_we    <= dm_req_we;
                r_addr  <= dm_req_addr;
                r_wdata <= dm_req_wdata;
                r_be    <= dm_req_be;
                if (!if_req_valid)
                    r_starve <= '0;
                else if (r_starve != STARVE_MAX)
                    r_starve <= r_starve + 4'd1;
            end else if (w_grant_if) begin
                r_is_dm  <= 1'b0;
                r_we     <= 1'b0;
                r_addr   <= if_req_addr;
                r_wdata  <= RESET_VALUE;
                r_be     <= MEM_BYTE_ENABLE_ALL;
                r_starve <= '0;
            end

            // Held at zero through ISSUE so WAIT always starts counting from 0.
            if (r_state == S_ISSUE)
                r_tmo <= '0;
            else if (r_state == S_WAIT)
                r_tmo <= r_tmo + 8'd1;

            if (w_rsp) begin
                if (r_is_dm) begin
                    r_dm_rsp_valid <= 1'b1;
                    r_dm_rsp_data  <= r_we ? RESET_VALUE : mem_rsp_data;
                end else begin
                    r_if_rsp_valid <= 1'b1;
                    r_if_rsp_data  <= mem_rsp_data;
                end
            end else if (w_timeout) begin
                r_err <= 1'b1;
                if (r_is_dm) begin
                    r_dm_rsp_valid <= 1'b1;
                    r_dm_rsp_data  <= RESET_VALUE;
                end else begin
                    r_if_rsp_valid <= 1'b1;
                    r_if_rsp_data  <= NOP_INSTRUCTION;
                end
            end
        end
    end

    assign if_req_ready  = w_grant_if;
    assign dm_req_ready  = w_grant_dm;
    assign if_rsp_valid  = r_if_rsp_valid;
    assign if_rsp_data   = r_if_rsp_data;
    assign dm_rsp_valid  = r_dm_rsp_valid;
    assign dm_rsp_data   = r_dm_rsp_data;
    assign mem_req_valid = (r_state == S_ISSUE);
    assign mem_req_we    = (r_state == S_ISSUE) && r_we;
    assign mem_req_addr  = r_addr;
    assign mem_req_wdata = r_wdata;
    assign mem_req_be    = r_be;
    assign busy          = (r_state != S_IDLE);
    assign err_timeout   = r_err;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed self-checking bench for riscv_mem_arbiter (STARVE_LIMIT=4, TIMEOUT_CYCLES=8).
module tb_riscv_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        dm_req_valid;
    logic        dm_req_we;
    logic [31:0] dm_req_addr;
    logic [31:0] dm_req_wdata;
    logic [3:0]  dm_req_be;
    logic        dm_req_ready;
    logic        dm_rsp_valid;
    logic [31:0] dm_rsp_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_be;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        busy;
    logic        err_timeout;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    riscv_mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .dm_req_valid(dm_req_valid), .dm_req_we(dm_req_we), .dm_req_addr(dm_req_addr),
        .dm_req_wdata(dm_req_wdata), .dm_req_be(dm_req_be), .dm_req_ready(dm_req_ready),
        .dm_rsp_valid(dm_rsp_valid), .dm_rsp_data(dm_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .busy(busy), .err_timeout(err_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] exp_if_grant;
        exp_if_grant = 10'b10_0001_0000;

        rst_n = 1'b0;
        if_req_valid = 1'b0; if_req_addr = '0;
        dm_req_valid = 1'b0; dm_req_we = 1'b0; dm_req_addr = '0; dm_req_wdata = '0; dm_req_be = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        step(); step();
        rst_n = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_memvalid", mem_req_valid, 0);
        chk("rst_ifrsp", if_rsp_valid, 0);
        chk("rst_dmrsp", dm_rsp_valid, 0);
        chk("rst_ifdata", if_rsp_data, 0);
        step();

        // IF-only read, zero-wait memory
        if_req_valid = 1'b1; if_req_addr = 32'h100; mem_req_ready = 1'b1; #1;
        chk("if1_ready", if_req_ready, 1);
        chk("if1_dmready", dm_req_ready, 0);
        step();
        if_req_valid = 1'b0;
        chk("if1_memvalid", mem_req_valid, 1);
        chk("if1_addr", mem_req_addr, 32'h100);
        chk("if1_be", mem_req_be, 4'hF);
        chk("if1_we", mem_req_we, 0);
        chk("if1_busy", busy, 1);
        step();
        chk("if1_wait_memvalid", mem_req_valid, 0);
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0050_0093;
        step();
        mem_rsp_valid = 1'b0;
        chk("if1_rspvalid", if_rsp_valid, 1);
        chk("if1_rspdata", if_rsp_data, 32'h0050_0093);
        chk("if1_busy_done", busy, 0);
        chk("if1_dmrsp", dm_rsp_valid, 0);
        step();
        chk("if1_pulse_end", if_rsp_valid, 0);

        // DM store with three stall cycles; a stray mem_rsp_valid in ISSUE is ignored
        dm_req_valid = 1'b1; dm_req_we = 1'b1; dm_req_addr = 32'h200;
        dm_req_wdata = 32'hDEAD_BEEF; dm_req_be = 4'h3; mem_req_ready = 1'b0; #1;
        chk("st_ready", dm_req_ready, 1);
        step();
        dm_req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_rsp_valid = (i == 0);
            chk("st_stall_valid", mem_req_valid, 1);
            chk("st_stall_addr", mem_req_addr, 32'h200);
            chk("st_stall_wdata", mem_req_wdata, 32'hDEAD_BEEF);
            chk("st_stall_be", mem_req_be, 4'h3);
            chk("st_stall_we", mem_req_we, 1);
            chk("st_stall_rsp", dm_rsp_valid, 0);
            step();
        end
        mem_rsp_valid = 1'b0; mem_req_ready = 1'b1;
        chk("st_hs_valid", mem_req_valid, 1);
        chk("st_hs_addr", mem_req_addr, 32'h200);
        chk("st_ignore_rsp", dm_rsp_valid, 0);
        step();
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_5678;
        step();
        mem_rsp_valid = 1'b0;
        chk("st_rspvalid", dm_rsp_valid, 1);
        chk("st_rspdata", dm_rsp_data, 0);
        chk("st_ifrsp", if_rsp_valid, 0);
        step();

        // Both ports requesting continuously: IF wins every fifth grant
        if_req_valid = 1'b1; if_req_addr = 32'h1000;
        dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_addr = 32'h2000; dm_req_be = 4'hF;
        mem_req_ready = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0;
        for (int g = 0; g < 10; g++) begin
            #1;
            chk("starve_grant", {30'b0, if_req_ready, dm_req_ready},
                exp_if_grant[g] ? 32'd2 : 32'd1);
            step(); step(); step();
        end
        if_req_valid = 1'b0; dm_req_valid = 1'b0; mem_rsp_valid = 1'b0;
        step();

        // IF request with no memory response: timeout after 8 WAIT cycles
        if_req_valid = 1'b1; if_req_addr = 32'h300; mem_req_ready = 1'b1; #1;
        chk("to_ready", if_req_ready, 1);
        step();
        if_req_valid = 1'b0;
        chk("to_hs", mem_req_valid, 1);
        step();
        mem_req_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            chk("to_wait_rsp", if_rsp_valid, 0);
            chk("to_wait_err", err_timeout, 0);
            step();
        end
        chk("to_rspvalid", if_rsp_valid, 1);
        chk("to_rspdata", if_rsp_data, 32'h0000_0013);
        chk("to_err", err_timeout, 1);
        chk("to_busy", busy, 0);
        step();
        chk("to_err_sticky", err_timeout, 1);
        chk("to_pulse_end", if_rsp_valid, 0);

        // Reset while in WAIT, late response afterwards
        dm_req_valid = 1'b1; dm_req_we = 1'b0; dm_req_addr = 32'h400; dm_req_be = 4'hF;
        mem_req_ready = 1'b1;
        step();
        dm_req_valid = 1'b0;
        step();
        chk("rw_busy_wait", busy, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE_F00D;
        chk("rw_busy", busy, 0);
        chk("rw_err", err_timeout, 0);
        chk("rw_memvalid", mem_req_valid, 0);
        chk("rw_addr", mem_req_addr, 0);
        chk("rw_ifdata", if_rsp_data, 0);
        step();
        mem_rsp_valid = 1'b0;
        chk("rw_no_dmrsp", dm_rsp_valid, 0);
        chk("rw_no_ifrsp", if_rsp_valid, 0);
        chk("rw_dmdata", dm_rsp_data, 0);
        dm_req_valid = 1'b1; dm_req_addr = 32'h404; #1;
        chk("rw_next_ready", dm_req_ready, 1);
        step();
        dm_req_valid = 1'b0;
        chk("rw_next_addr", mem_req_addr, 32'h404);
        chk("rw_next_we", mem_req_we, 0);
        step();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1122_3344;
        step();
        mem_rsp_valid = 1'b0;
        chk("rw_next_rsp", dm_rsp_valid, 1);
        chk("rw_next_data", dm_rsp_data, 32'h1122_3344);
        step();

        // Response on exactly the timeout cycle wins
        if_req_valid = 1'b1; if_req_addr = 32'h500; mem_req_ready = 1'b1;
        step();
        if_req_valid = 1'b0;
        step();
        mem_req_ready = 1'b0;
        for (int i = 1; i <= 7; i++) step();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h00A0_0113;
        step();
        mem_rsp_valid = 1'b0;
        chk("edge_rspvalid", if_rsp_valid, 1);
        chk("edge_rspdata", if_rsp_data, 32'h00A0_0113);
        chk("edge_err", err_timeout, 0);
        step();
        chk("edge_err_after", err_timeout, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
Arbitrates the pipeline's instruction-fetch (IF) port and data-memory (DM) port onto one unified single-ported memory interface. Handles one transaction in flight, with valid/ready request and pulse responses, and data-side priority plus an IF anti-starvation counter. A response timeout returns a safe value: NOP_INSTRUCTION for IF, RESET_VALUE for DM. The block sits between the IF/MEM stages and the external memory; the pipeline's hazard logic stalls IF or MEM while the corresponding req_ready is low.

Parameters:
STARVE_LIMIT, 4, consecutive DM grants while IF is pending before IF is forced to win one grant (1..15)
TIMEOUT_CYCLES, 255, cycles in WAIT with no mem_rsp_valid before the transaction is aborted (1..255)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
if_req_valid  in  1  IF read request; held stable until if_req_ready
if_req_addr  in  32  IF fetch address
if_req_ready  out  1  IF request accepted this cycle
if_rsp_valid  out  1  one-cycle pulse, if_rsp_data valid
if_rsp_data  out  32  fetched instruction
dm_req_valid  in  1  DM request; held stable until dm_req_ready
dm_req_we  in  1  1 = store, 0 = load
dm_req_addr  in  32  DM address
dm_req_wdata  in  32  store data
dm_req_be  in  4  byte enables
dm_req_ready  out  1  DM request accepted this cycle
dm_rsp_valid  out  1  one-cycle pulse; load data, or store acknowledge
dm_rsp_data  out  32  load data; RESET_VALUE for stores
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  write strobe
mem_req_addr  out  32  address
mem_req_wdata  out  32  write data
mem_req_be  out  4  byte enables; MEM_BYTE_ENABLE_ALL for IF
mem_rsp_valid  in  1  memory response (read data or write ack)
mem_rsp_data  in  32  read data
busy  out  1  FSM not in IDLE
err_timeout  out  1  sticky; set on any timeout, cleared only by reset

Behaviour:
- Reset (rst_n=0 at rising edge):
  - FSM goes to IDLE.
  - All outputs go to 0; *_data outputs go to RESET_VALUE.
  - Starvation counter, timeout counter and err_timeout are cleared.
  - Reset mid-transaction abandons the transaction with no response pulse. A late mem_rsp_valid after reset is ignored.
- FSM states:
  - IDLE: accepts a request.
  - ISSUE: mem_req_valid=1; leaves on mem_req_ready.
  - WAIT: waits for mem_rsp_valid or timeout.
- IDLE arbitration is combinational, giving ready in the same cycle:
  - DM only pending: grant DM.
  - IF only pending: grant IF.
  - Both pending: grant DM, unless the starvation count equals STARVE_LIMIT, in which case grant IF.
  - The granted req_ready=1 for exactly one cycle. The request fields are latched, and the FSM goes to ISSUE next cycle.
- Starvation counter:
  - Increments on each DM grant while if_req_valid=1.
  - Clears on any IF grant, and on a DM grant while if_req_valid=0.
  - Saturates at STARVE_LIMIT.
- ISSUE:
  - mem_req_* driven from the latched fields and held stable until mem_req_ready=1.
  - IF drives we=0 and be=MEM_BYTE_ENABLE_ALL.
  - On the handshake cycle, go to WAIT and clear the timeout counter.
- WAIT:
  - mem_req_valid=0; the timeout counter increments each cycle.
  - If mem_rsp_valid=1 at cycle R:
    - At R+1 the granted port sees rsp_valid=1.
    - rsp_data = mem_rsp_data for IF and DM loads; RESET_VALUE for DM stores.
    - FSM is back in IDLE at R+1, so a new grant is possible in cycle R+1.
  - If the counter reaches TIMEOUT_CYCLES first:
    - Next cycle, rsp_valid pulses with data NOP_INSTRUCTION (IF) or RESET_VALUE (DM).
    - err_timeout is set and the FSM returns to IDLE.
  - If mem_rsp_valid arrives in the same cycle as the timeout, the response wins and no error is raised.
- mem_rsp_valid is ignored in IDLE and ISSUE.
- Minimum latency, zero-wait memory: accept at T, mem handshake at T+1, mem_rsp at T+2, rsp pulse at T+3.
- At most one of if_req_ready/dm_req_ready is high at any time; likewise at most one of if_rsp_valid/dm_rsp_valid.

Test Plan:
- IF-only read, addr 0x100, memory returns 0x00500093 with zero wait: if_req_ready at T; mem_req_valid with addr 0x100, be 0xF at T+1; if_rsp_valid with data 0x00500093 at T+3; busy low at T+3.
- DM store, addr 0x200, wdata 0xDEADBEEF, be 0x3, mem_req_ready held low 3 cycles: mem_req fields stable throughout; dm_rsp_valid with data 0 one cycle after mem ack.
- Both ports continuously requesting, STARVE_LIMIT=4: grant order DM,DM,DM,DM,IF,DM,DM,DM,DM,IF.
- No mem_rsp_valid for an IF request, TIMEOUT_CYCLES=8: if_rsp_valid with data 0x00000013 nine cycles after the mem handshake; err_timeout=1 and stays set.
- rst_n low for one cycle while in WAIT, then mem_rsp_valid arrives: no rsp pulse; all outputs 0; busy=0; next request is served normally.
- mem_rsp_valid on exactly the timeout cycle: normal response data is delivered and err_timeout stays 0.
